// File: rtl/mem_region_router.sv
// Routes one host req/gnt/rvalid stream to NUM_REGIONS equal-sized regions with read-only
// enforcement and in-order responses. Define MEM_REGION_ROUTER_PERF_EN to enable stall_cnt_o.
module mem_region_router #(
    parameter int unsigned            NUM_REGIONS     = 2,
    parameter logic [31:0]            REGION_SIZE     = 32'h0002_0000,
    parameter int unsigned            AW              = 32,
    parameter int unsigned            DW              = 32,
    parameter int unsigned            MAX_OUTSTANDING = 4,
    parameter logic [NUM_REGIONS-1:0] RO_MASK         = NUM_REGIONS'(1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      host_req_i,
    input  logic                      host_we_i,
    input  logic [AW-1:0]             host_addr_i,
    input  logic [DW-1:0]             host_wdata_i,
    input  logic [DW/8-1:0]           host_wmask_i,
    output logic                      host_gnt_o,
    output logic                      host_rvalid_o,
    output logic [DW-1:0]             host_rdata_o,
    output logic                      host_rerror_o,
    output logic [NUM_REGIONS-1:0]    reg_req_o,
    output logic                      reg_we_o,
    output logic [AW-1:0]             reg_addr_o,
    output logic [DW-1:0]             reg_wdata_o,
    output logic [DW/8-1:0]           reg_wmask_o,
    input  logic [NUM_REGIONS-1:0]    reg_gnt_i,
    input  logic [NUM_REGIONS-1:0]    reg_rvalid_i,
    input  logic [NUM_REGIONS*DW-1:0] reg_rdata_i,
    input  logic [NUM_REGIONS-1:0]    reg_rerror_i,
    output logic                      proto_err_o,
    output logic [31:0]               stall_cnt_o
);

    localparam int unsigned     SEL_BIT  = $clog2(REGION_SIZE);
    localparam int unsigned     IDXW     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned     OW       = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [AW-1:0]   OFF_MASK = AW'(REGION_SIZE - 32'd1);

    logic [IDXW-1:0]        idx;
    logic [IDXW-1:0]        cur_idx;
    logic                   cur_err;
    logic                   in_range;
    logic                   dec_err;
    logic                   tgt_err;
    logic                   ro_hit;
    logic                   region_gnt;
    logic                   stall;
    logic                   accept;
    logic                   err_pend;
    logic [OW-1:0]          outstanding;
    logic [NUM_REGIONS-1:0] exp_mask;

    assign reg_we_o    = host_we_i;
    assign reg_addr_o  = host_addr_i & OFF_MASK;
    assign reg_wdata_o = host_wdata_i;
    assign reg_wmask_o = host_wmask_i;

    // A target is {err flag, region index}; any change of target waits for the pipe to drain.
    always_comb begin
        idx        = host_addr_i[SEL_BIT +: IDXW];
        in_range   = 1'b0;
        ro_hit     = 1'b0;
        region_gnt = 1'b0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (idx == IDXW'(r)) begin
                in_range   = 1'b1;
                ro_hit     = RO_MASK[r];
                region_gnt = reg_gnt_i[r];
            end
        end
        dec_err = ((host_addr_i >> (SEL_BIT + IDXW)) != '0) || !in_range;
        tgt_err = dec_err || (host_we_i && ro_hit);
        stall   = (outstanding == OW'(MAX_OUTSTANDING)) ||
                  ((outstanding != '0) &&
                   ((tgt_err != cur_err) || (!tgt_err && (idx != cur_idx))));
        host_gnt_o = host_req_i && !stall && (tgt_err || region_gnt);
        accept     = host_gnt_o;
        reg_req_o  = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            reg_req_o[r] = host_req_i && !stall && !tgt_err && (idx == IDXW'(r));
        end
    end

    always_comb begin
        exp_mask      = '0;
        host_rvalid_o = 1'b0;
        host_rdata_o  = '0;
        host_rerror_o = 1'b0;
        if (cur_err) begin
            host_rvalid_o = err_pend;
            host_rerror_o = err_pend;
        end else if (outstanding != '0) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (cur_idx == IDXW'(r)) begin
                    exp_mask[r]   = 1'b1;
                    host_rvalid_o = reg_rvalid_i[r];
                    host_rdata_o  = reg_rdata_i[r*DW +: DW];
                    host_rerror_o = reg_rerror_i[r];
                end
            end
        end
    end

    // Responses from any region other than the current one, or with nothing in flight, are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
            cur_err     <= 1'b0;
            cur_idx     <= '0;
            err_pend    <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            if (accept && !host_rvalid_o) begin
                outstanding <= outstanding + OW'(1);
            end else if (!accept && host_rvalid_o) begin
                outstanding <= outstanding - OW'(1);
            end
            if (accept) begin
                cur_err <= tgt_err;
                cur_idx <= tgt_err ? '0 : idx;
            end
            err_pend <= accept && tgt_err;
            if ((reg_rvalid_i & ~exp_mask) != '0) begin
                proto_err_o <= 1'b1;
            end
        end
    end

`ifdef MEM_REGION_ROUTER_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (host_req_i && stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
